// File: rtl/fact_pkg.sv
// Shared types and defaults for the factorial controller.
// Used by fact_ctrl (optional build macro FACT_CTRL_CYCLE_CNT_EN) and its timer.
package fact_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned MAX_N_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    MULT,
    DONE,
    ERR
  } state_t;

  localparam logic SEL_ONE  = 1'b0;
  localparam logic SEL_PROD = 1'b1;

endpackage

// File: rtl/fact_lat_timer.sv
// Wait counter stretching each MULT visit to MUL_LAT+1 cycles.
// expire is combinational on the count, so MUL_LAT=0 expires on the first cycle.
module fact_lat_timer #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expire
);

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  logic [3:0] cnt_q;

  assign expire = (cnt_q == LAT);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt_q <= '0;
    end else if (!expire) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/fact_ctrl.sv
// Moore sequencer for the iterative factorial datapath (counter, product register, multiplier).
// Build macro FACT_CTRL_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_N   = MAX_N_DEF,
  parameter int unsigned MUL_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [CNT_W-1:0] n,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             Load_cnt,
  output logic             EN,
  output logic             load_reg,
  output logic             sel,
  output logic             done,
  output logic             err,
  output logic             busy
`ifdef FACT_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]      cycles
`endif
);

  localparam logic [CNT_W-1:0] MAX_N_L = CNT_W'(MAX_N);
  localparam logic [CNT_W-1:0] ONE_L   = CNT_W'(1);

  state_t state_q, state_d;
  logic   expire;

  // Timer is held clear outside MULT, so every MULT entry starts from zero.
  fact_lat_timer #(
    .MUL_LAT(MUL_LAT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (state_q != MULT),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    Load_cnt = 1'b0;
    EN       = 1'b0;
    load_reg = 1'b0;
    sel      = SEL_ONE;
    done     = 1'b0;
    err      = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = (n > MAX_N_L) ? ERR : INIT;
        end
      end
      INIT: begin
        Load_cnt = 1'b1;
        load_reg = 1'b1;
        sel      = SEL_ONE;
        busy     = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_d = (cnt_q > ONE_L) ? MULT : DONE;
      end
      MULT: begin
        busy = 1'b1;
        sel  = SEL_PROD;
        if (expire) begin
          load_reg = 1'b1;
          EN       = 1'b1;
          state_d  = CHECK;
        end
      end
      DONE: begin
        done = 1'b1;
        sel  = SEL_PROD;
        if (!go) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        err = 1'b1;
        if (!go) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FACT_CTRL_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else if (state_q == IDLE && state_d == INIT) begin
      cycles <= '0;
    end else if (busy && cycles != '1) begin
      cycles <= cycles + 16'd1;
    end
  end
`endif

endmodule
